hazard_controller: RTL and testbench

HAZARD_CONTROLLER -- requirements
Module: hazard_controller

---
 rtl/pipe_pkg.sv | 25 ++
 rtl/hazard_controller_forward_unit.sv | 23 ++
 rtl/hazard_controller.sv | 148 ++++++++++++++
 tb/tb_hazard_controller.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard controller:
// memory FSM states, writeback select codes and forwarding selects.
package pipe_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    DONE = 3'd3,
    ERR  = 3'd4
  } mem_state_e;

  localparam logic [1:0] WB_MEM = 2'b01;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  // A later stage can supply a source only if it writes a non-x0 register with that index.
  function automatic logic src_match(input logic [4:0] rd, input logic wren,
                                     input logic [4:0] rs);
    return wren && (rd != 5'd0) && (rd == rs);
  endfunction

endpackage

// File: rtl/hazard_controller_forward_unit.sv
// Operand bypass select for one execute-stage source register.
// M is newer than W, so it wins when both hold the register.
module forward_unit
  import pipe_pkg::*;
(
  input  logic [4:0] rs_addrE,
  input  logic [4:0] rd_addrM,
  input  logic       rd_wrenM,
  input  logic [4:0] rd_addrW,
  input  logic       rd_wrenW,
  output logic [1:0] fwd_sel
);

  always_comb begin
    fwd_sel = FWD_RF;
    if (src_match(rd_addrM, rd_wrenM, rs_addrE)) begin
      fwd_sel = FWD_M;
    end else if (src_match(rd_addrW, rd_wrenW, rs_addrE)) begin
      fwd_sel = FWD_W;
    end
  end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard controller: data-memory access FSM with timeout,
// stall/flush arbitration (memory > branch > load-use) and operand forwarding.
module hazard_controller
  import pipe_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic       clk,
  input  logic       aclr,
  input  logic [4:0] rs1_addrD,
  input  logic [4:0] rs2_addrD,
  input  logic       rs1_usedD,
  input  logic       rs2_usedD,
  input  logic [4:0] rs1_addrE,
  input  logic [4:0] rs2_addrE,
  input  logic [4:0] rd_addrE,
  input  logic [4:0] rd_addrM,
  input  logic [4:0] rd_addrW,
  input  logic       rd_wrenE,
  input  logic       rd_wrenM,
  input  logic       rd_wrenW,
  input  logic [1:0] wb_selE,
  input  logic       br_takenE,
  input  logic       mem_accessM,
  input  logic       dmem_ack,
  output logic       dmem_req,
  output logic       stallF,
  output logic       stallD,
  output logic       stallE,
  output logic       stallM,
  output logic       flushD,
  output logic       flushE,
  output logic       flushW,
  output logic [1:0] fwd_selA,
  output logic [1:0] fwd_selB,
  output logic       mem_err,
  output logic [2:0] dbg_state_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  mem_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             mem_stall;
  logic             load_use;

  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Memory handshake: dmem_req is a one-cycle pulse issued in REQ; the memory
  // answers with a one-cycle dmem_ack at any later time (or in REQ itself).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (mem_accessM) state_d = REQ;
      end
      REQ: begin
        if (dmem_ack) begin
          state_d = DONE;
        end else begin
          state_d = WAIT;
          cnt_d   = '0;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + CNT_ONE;
        if (dmem_ack) begin
          state_d = DONE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ERR;
          err_d   = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign dmem_req    = (state_q == REQ);
  assign mem_err     = err_q;
  assign dbg_state_o = state_q;

  assign mem_stall = mem_accessM && (state_q != DONE) && (state_q != ERR);

  assign load_use = (wb_selE == WB_MEM) && rd_wrenE && (rd_addrE != 5'd0) &&
                    ((rs1_usedD && (rs1_addrD == rd_addrE)) ||
                     (rs2_usedD && (rs2_addrD == rd_addrE)));

  // The taken branch is held in E during a memory stall, so it is ignored there.
  always_comb begin
    stallF = 1'b0;
    stallD = 1'b0;
    stallE = 1'b0;
    stallM = 1'b0;
    flushD = 1'b0;
    flushE = 1'b0;
    flushW = 1'b0;
    if (mem_stall) begin
      stallF = 1'b1;
      stallD = 1'b1;
      stallE = 1'b1;
      stallM = 1'b1;
      flushW = 1'b1;
    end else if (br_takenE) begin
      flushD = 1'b1;
      flushE = 1'b1;
    end else if (load_use) begin
      stallF = 1'b1;
      stallD = 1'b1;
      flushE = 1'b1;
    end
  end

  forward_unit u_fwd_a (
    .rs_addrE (rs1_addrE),
    .rd_addrM (rd_addrM),
    .rd_wrenM (rd_wrenM),
    .rd_addrW (rd_addrW),
    .rd_wrenW (rd_wrenW),
    .fwd_sel  (fwd_selA)
  );

  forward_unit u_fwd_b (
    .rs_addrE (rs2_addrE),
    .rd_addrM (rd_addrM),
    .rd_wrenM (rd_wrenM),
    .rd_addrW (rd_addrW),
    .rd_wrenW (rd_wrenW),
    .fwd_sel  (fwd_selB)
  );

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller: reset, forwarding, load-use, branch
// priority, memory FSM latency/timeout and reset during an access.
module tb_hazard_controller;
  import pipe_pkg::*;

  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 3;

  // Control vector order: {stallF, stallD, stallE, stallM, flushD, flushE, flushW}
  localparam logic [6:0] C_NONE = 7'b0000000;
  localparam logic [6:0] C_MEM  = 7'b1111001;
  localparam logic [6:0] C_BR   = 7'b0000110;
  localparam logic [6:0] C_LU   = 7'b1100010;

  logic       clk;
  logic       aclr;
  logic [4:0] rs1_addrD, rs2_addrD, rs1_addrE, rs2_addrE;
  logic       rs1_usedD, rs2_usedD;
  logic [4:0] rd_addrE, rd_addrM, rd_addrW;
  logic       rd_wrenE, rd_wrenM, rd_wrenW;
  logic [1:0] wb_selE;
  logic       br_takenE, mem_accessM, dmem_ack;
  logic       dmem_req;
  logic       stallF, stallD, stallE, stallM, flushD, flushE, flushW;
  logic [1:0] fwd_selA, fwd_selB;
  logic       mem_err;
  logic [2:0] dbg_state;
  logic [6:0] ctrl;

  int n_checks = 0;
  int n_errors = 0;

  hazard_controller #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .aclr        (aclr),
    .rs1_addrD   (rs1_addrD),
    .rs2_addrD   (rs2_addrD),
    .rs1_usedD   (rs1_usedD),
    .rs2_usedD   (rs2_usedD),
    .rs1_addrE   (rs1_addrE),
    .rs2_addrE   (rs2_addrE),
    .rd_addrE    (rd_addrE),
    .rd_addrM    (rd_addrM),
    .rd_addrW    (rd_addrW),
    .rd_wrenE    (rd_wrenE),
    .rd_wrenM    (rd_wrenM),
    .rd_wrenW    (rd_wrenW),
    .wb_selE     (wb_selE),
    .br_takenE   (br_takenE),
    .mem_accessM (mem_accessM),
    .dmem_ack    (dmem_ack),
    .dmem_req    (dmem_req),
    .stallF      (stallF),
    .stallD      (stallD),
    .stallE      (stallE),
    .stallM      (stallM),
    .flushD      (flushD),
    .flushE      (flushE),
    .flushW      (flushW),
    .fwd_selA    (fwd_selA),
    .fwd_selB    (fwd_selB),
    .mem_err     (mem_err),
    .dbg_state_o (dbg_state)
  );

  assign ctrl = {stallF, stallD, stallE, stallM, flushD, flushE, flushW};

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change right after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    rs1_addrD = '0; rs2_addrD = '0; rs1_usedD = 1'b0; rs2_usedD = 1'b0;
    rs1_addrE = '0; rs2_addrE = '0;
    rd_addrE = '0; rd_addrM = '0; rd_addrW = '0;
    rd_wrenE = 1'b0; rd_wrenM = 1'b0; rd_wrenW = 1'b0;
    wb_selE = 2'b00; br_takenE = 1'b0; mem_accessM = 1'b0; dmem_ack = 1'b0;
  endtask

  initial begin
    aclr = 1'b0;
    clear_inputs();
    #1;
    check_eq("rst_state", 8'(dbg_state), 8'(IDLE));
    check_eq("rst_req", 8'(dmem_req), 8'd0);
    check_eq("rst_err", 8'(mem_err), 8'd0);
    check_eq("rst_ctrl", 8'(ctrl), 8'(C_NONE));
    // Combinational paths stay live during reset
    rd_addrM = 5'd3; rd_wrenM = 1'b1; rs1_addrE = 5'd3;
    #1;
    check_eq("rst_fwdA_live", 8'(fwd_selA), 8'(FWD_M));
    step();
    step();
    aclr = 1'b1;
    clear_inputs();

    // Forwarding
    rd_addrM = 5'd7; rd_addrW = 5'd7; rd_wrenM = 1'b1; rd_wrenW = 1'b1; rs2_addrE = 5'd7;
    #1;
    check_eq("fwdB_m_over_w", 8'(fwd_selB), 8'(FWD_M));
    check_eq("fwdA_none", 8'(fwd_selA), 8'(FWD_RF));
    rd_wrenM = 1'b0;
    #1;
    check_eq("fwdB_w_only", 8'(fwd_selB), 8'(FWD_W));
    rd_wrenM = 1'b1; rd_addrM = 5'd0; rd_addrW = 5'd0; rs2_addrE = 5'd0;
    #1;
    check_eq("fwdB_x0", 8'(fwd_selB), 8'(FWD_RF));
    rd_addrM = 5'd9; rd_addrW = 5'd4; rs1_addrE = 5'd4; rs2_addrE = 5'd9;
    #1;
    check_eq("fwdA_w", 8'(fwd_selA), 8'(FWD_W));
    check_eq("fwdB_m", 8'(fwd_selB), 8'(FWD_M));
    rd_wrenW = 1'b0;
    #1;
    check_eq("fwdA_w_nowren", 8'(fwd_selA), 8'(FWD_RF));

    // Load-use
    clear_inputs();
    wb_selE = WB_MEM; rd_wrenE = 1'b1; rd_addrE = 5'd5; rs1_addrD = 5'd5; rs1_usedD = 1'b1;
    #1;
    check_eq("lu_rs1", 8'(ctrl), 8'(C_LU));
    rs1_usedD = 1'b0;
    #1;
    check_eq("lu_unused", 8'(ctrl), 8'(C_NONE));
    rs2_addrD = 5'd5; rs2_usedD = 1'b1;
    #1;
    check_eq("lu_rs2", 8'(ctrl), 8'(C_LU));
    wb_selE = 2'b00;
    #1;
    check_eq("lu_not_load", 8'(ctrl), 8'(C_NONE));
    wb_selE = WB_MEM; rd_addrE = 5'd0; rs2_addrD = 5'd0;
    #1;
    check_eq("lu_x0", 8'(ctrl), 8'(C_NONE));
    rd_addrE = 5'd5; rs2_addrD = 5'd5; rd_wrenE = 1'b0;
    #1;
    check_eq("lu_nowren", 8'(ctrl), 8'(C_NONE));
    rd_wrenE = 1'b1; br_takenE = 1'b1;
    #1;
    check_eq("br_over_lu", 8'(ctrl), 8'(C_BR));
    // Dependent instruction reaches E while the load sits in W
    step();
    clear_inputs();
    rs1_addrE = 5'd5; rd_addrW = 5'd5; rd_wrenW = 1'b1;
    #1;
    check_eq("lu_then_fwdA", 8'(fwd_selA), 8'(FWD_W));
    check_eq("lu_then_ctrl", 8'(ctrl), 8'(C_NONE));

    // Memory access, ack on first WAIT cycle; branch ignored while stalled
    clear_inputs();
    mem_accessM = 1'b1; br_takenE = 1'b1;
    #1;
    check_eq("m1_idle_state", 8'(dbg_state), 8'(IDLE));
    check_eq("m1_idle_ctrl", 8'(ctrl), 8'(C_MEM));
    check_eq("m1_idle_req", 8'(dmem_req), 8'd0);
    step();
    br_takenE = 1'b0;
    #1;
    check_eq("m1_req_state", 8'(dbg_state), 8'(REQ));
    check_eq("m1_req_pulse", 8'(dmem_req), 8'd1);
    check_eq("m1_req_ctrl", 8'(ctrl), 8'(C_MEM));
    step();
    dmem_ack = 1'b1;
    #1;
    check_eq("m1_wait_state", 8'(dbg_state), 8'(WAIT));
    check_eq("m1_wait_req", 8'(dmem_req), 8'd0);
    check_eq("m1_wait_ctrl", 8'(ctrl), 8'(C_MEM));
    step();
    dmem_ack = 1'b0;
    #1;
    check_eq("m1_done_state", 8'(dbg_state), 8'(DONE));
    check_eq("m1_done_ctrl", 8'(ctrl), 8'(C_NONE));
    check_eq("m1_done_req", 8'(dmem_req), 8'd0);
    step();
    mem_accessM = 1'b0;
    #1;
    check_eq("m1_back_idle", 8'(dbg_state), 8'(IDLE));

    // Ack in REQ: minimum 3-cycle latency
    mem_accessM = 1'b1;
    step();
    dmem_ack = 1'b1;
    #1;
    check_eq("m2_req_state", 8'(dbg_state), 8'(REQ));
    step();
    dmem_ack = 1'b0;
    #1;
    check_eq("m2_done_state", 8'(dbg_state), 8'(DONE));
    check_eq("m2_done_ctrl", 8'(ctrl), 8'(C_NONE));
    step();
    mem_accessM = 1'b0;

    // Ack on the last WAIT cycle wins over timeout
    mem_accessM = 1'b1;
    step();
    for (int i = 0; i < TIMEOUT; i++) begin
      step();
      if (i == TIMEOUT - 1) dmem_ack = 1'b1;
      #1;
      check_eq($sformatf("m3_wait%0d", i), 8'(dbg_state), 8'(WAIT));
    end
    step();
    dmem_ack = 1'b0;
    #1;
    check_eq("m3_done_state", 8'(dbg_state), 8'(DONE));
    check_eq("m3_no_err", 8'(mem_err), 8'd0);
    step();
    mem_accessM = 1'b0;

    // Timeout: TIMEOUT WAIT cycles then ERR
    mem_accessM = 1'b1;
    step();
    for (int i = 0; i < TIMEOUT; i++) begin
      step();
      #1;
      check_eq($sformatf("m4_wait%0d", i), 8'(dbg_state), 8'(WAIT));
      check_eq($sformatf("m4_wait%0d_ctrl", i), 8'(ctrl), 8'(C_MEM));
    end
    step();
    #1;
    check_eq("m4_err_state", 8'(dbg_state), 8'(ERR));
    check_eq("m4_err_ctrl", 8'(ctrl), 8'(C_NONE));
    step();
    mem_accessM = 1'b0;
    #1;
    check_eq("m4_idle_state", 8'(dbg_state), 8'(IDLE));
    check_eq("m4_err_flag", 8'(mem_err), 8'd1);
    step();
    step();
    check_eq("m4_err_sticky", 8'(mem_err), 8'd1);

    // Reset during WAIT abandons the access
    mem_accessM = 1'b1;
    step();
    step();
    #1;
    check_eq("m5_wait_state", 8'(dbg_state), 8'(WAIT));
    aclr = 1'b0;
    #1;
    check_eq("m5_rst_state", 8'(dbg_state), 8'(IDLE));
    check_eq("m5_rst_req", 8'(dmem_req), 8'd0);
    check_eq("m5_rst_err_clr", 8'(mem_err), 8'd0);
    check_eq("m5_rst_ctrl", 8'(ctrl), 8'(C_MEM));
    step();
    #1;
    check_eq("m5_rst_hold", 8'(dbg_state), 8'(IDLE));
    check_eq("m5_rst_hold_req", 8'(dmem_req), 8'd0);
    aclr = 1'b1;
    step();
    #1;
    check_eq("m5_fresh_req", 8'(dbg_state), 8'(REQ));
    check_eq("m5_fresh_pulse", 8'(dmem_req), 8'd1);
    step();
    #1;
    check_eq("m5_pulse_once", 8'(dmem_req), 8'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
